// File: rtl/sprite_motion.sv
// Motion controller for one on-screen sprite: a programmable tick divider and
// a per-tick position update in wrap, clamp, bounce or hold mode.
module sprite_motion #(
    parameter int unsigned HOR_FIELD = 800,
    parameter int unsigned VER_FIELD = 600,
    parameter int unsigned SIZE      = 25,
    parameter int unsigned HOR_W     = 12,
    parameter int unsigned VER_W     = 11,
    parameter int unsigned TICK_DIV  = 1048576,
    parameter int unsigned RESET_HOR = 0,
    parameter int unsigned RESET_VER = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [3:0]       control,
    input  logic [1:0]       mode,
    input  logic [3:0]       speed,
    output logic [HOR_W-1:0] hor_pos,
    output logic [VER_W-1:0] ver_pos,
    output logic             tick,
    output logic [1:0]       hit
);

    localparam int unsigned HMAX  = HOR_FIELD - SIZE;
    localparam int unsigned VMAX  = VER_FIELD - SIZE;
    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned HW    = HOR_W + 2;
    localparam int unsigned VW    = VER_W + 2;

    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic signed [HW-1:0] HMAX_S  = HW'(HMAX);
    localparam logic signed [HW-1:0] HMOD_S  = HW'(HMAX + 1);
    localparam logic signed [HW-1:0] H2MAX_S = HW'(2 * HMAX);
    localparam logic signed [VW-1:0] VMAX_S  = VW'(VMAX);
    localparam logic signed [VW-1:0] VMOD_S  = VW'(VMAX + 1);
    localparam logic signed [VW-1:0] V2MAX_S = VW'(2 * VMAX);

    typedef enum logic [1:0] {
        ModeWrap   = 2'd0,
        ModeClamp  = 2'd1,
        ModeBounce = 2'd2,
        ModeHold   = 2'd3
    } mode_e;

    logic [CNT_W-1:0] r_cnt;
    logic             r_tick;
    logic [HOR_W-1:0] r_hor;
    logic [VER_W-1:0] r_ver;
    logic             r_dx;
    logic             r_dy;
    logic [1:0]       r_hit;

    mode_e               w_mode;
    logic                w_h_move, w_h_inc, w_v_move, w_v_inc;
    logic signed [HW-1:0] w_h_cur, w_h_step, w_h_sum;
    logic signed [VW-1:0] w_v_cur, w_v_step, w_v_sum;
    logic                w_h_over, w_h_under, w_v_over, w_v_under;
    logic [HOR_W-1:0]    w_h_next;
    logic [VER_W-1:0]    w_v_next;
    logic                w_h_hit, w_v_hit, w_dx_next, w_dy_next;

    assign w_mode = mode_e'(mode);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_cnt  <= (r_cnt == CNT_LAST) ? '0 : r_cnt + CNT_W'(1);
            r_tick <= (r_cnt == CNT_LAST);
        end
    end

    // control = {up, down, left, right}; opposing pairs cancel.
    always_comb begin
        w_h_move = 1'b0;
        w_h_inc  = 1'b0;
        w_v_move = 1'b0;
        w_v_inc  = 1'b0;
        if (w_mode == ModeBounce) begin
            w_h_move = 1'b1;
            w_h_inc  = r_dx;
            w_v_move = 1'b1;
            w_v_inc  = r_dy;
        end else if (w_mode != ModeHold) begin
            w_h_move = control[0] ^ control[1];
            w_h_inc  = control[0];
            w_v_move = control[3] ^ control[2];
            w_v_inc  = control[2];
        end
    end

    assign w_h_cur  = signed'({2'b00, r_hor});
    assign w_v_cur  = signed'({2'b00, r_ver});
    assign w_h_step = signed'({{(HW - 4){1'b0}}, speed});
    assign w_v_step = signed'({{(VW - 4){1'b0}}, speed});

    assign w_h_sum = !w_h_move ? w_h_cur :
                     (w_h_inc ? w_h_cur + w_h_step : w_h_cur - w_h_step);
    assign w_v_sum = !w_v_move ? w_v_cur :
                     (w_v_inc ? w_v_cur + w_v_step : w_v_cur - w_v_step);

    assign w_h_under = w_h_sum[HW-1];
    assign w_v_under = w_v_sum[VW-1];
    assign w_h_over  = !w_h_under && (w_h_sum > HMAX_S);
    assign w_v_over  = !w_v_under && (w_v_sum > VMAX_S);

    always_comb begin
        w_h_next  = HOR_W'(w_h_sum);
        w_h_hit   = 1'b0;
        w_dx_next = r_dx;
        unique case (w_mode)
            ModeWrap: begin
                if (w_h_under) begin
                    w_h_next = HOR_W'(w_h_sum + HMOD_S);
                end else if (w_h_over) begin
                    w_h_next = HOR_W'(w_h_sum - HMOD_S);
                end
            end
            ModeClamp: begin
                if (w_h_under) begin
                    w_h_next = '0;
                    w_h_hit  = 1'b1;
                end else if (w_h_over) begin
                    w_h_next = HOR_W'(HMAX_S);
                    w_h_hit  = 1'b1;
                end
            end
            ModeBounce: begin
                if (w_h_over) begin
                    w_h_next  = HOR_W'(H2MAX_S - w_h_sum);
                    w_dx_next = ~r_dx;
                    w_h_hit   = 1'b1;
                end else if (w_h_under) begin
                    w_h_next  = HOR_W'(-w_h_sum);
                    w_dx_next = ~r_dx;
                    w_h_hit   = 1'b1;
                end
            end
            ModeHold: begin
                w_h_next = r_hor;
            end
        endcase
    end

    always_comb begin
        w_v_next  = VER_W'(w_v_sum);
        w_v_hit   = 1'b0;
        w_dy_next = r_dy;
        unique case (w_mode)
            ModeWrap: begin
                if (w_v_under) begin
                    w_v_next = VER_W'(w_v_sum + VMOD_S);
                end else if (w_v_over) begin
                    w_v_next = VER_W'(w_v_sum - VMOD_S);
                end
            end
            ModeClamp: begin
                if (w_v_under) begin
                    w_v_next = '0;
                    w_v_hit  = 1'b1;
                end else if (w_v_over) begin
                    w_v_next = VER_W'(VMAX_S);
                    w_v_hit  = 1'b1;
                end
            end
            ModeBounce: begin
                if (w_v_over) begin
                    w_v_next  = VER_W'(V2MAX_S - w_v_sum);
                    w_dy_next = ~r_dy;
                    w_v_hit   = 1'b1;
                end else if (w_v_under) begin
                    w_v_next  = VER_W'(-w_v_sum);
                    w_dy_next = ~r_dy;
                    w_v_hit   = 1'b1;
                end
            end
            ModeHold: begin
                w_v_next = r_ver;
            end
        endcase
    end

    // Reset has priority over a pending tick update.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_hor <= HOR_W'(RESET_HOR);
            r_ver <= VER_W'(RESET_VER);
            r_dx  <= 1'b1;
            r_dy  <= 1'b1;
            r_hit <= 2'b00;
        end else if (r_tick) begin
            r_hor <= w_h_next;
            r_ver <= w_v_next;
            r_dx  <= w_dx_next;
            r_dy  <= w_dy_next;
            r_hit <= {w_h_hit, w_v_hit};
        end else begin
            r_hit <= 2'b00;
        end
    end

    assign hor_pos = r_hor;
    assign ver_pos = r_ver;
    assign tick    = r_tick;
    assign hit     = r_hit;

endmodule

// File: tb/tb_sprite_motion.sv
// Directed bench for sprite_motion with a 40x30 field, 8-pixel sprite and a
// 4-cycle tick (HMAX=32, VMAX=22).
module tb_sprite_motion;

    logic        clock;
    logic        reset;
    logic [3:0]  control;
    logic [1:0]  mode;
    logic [3:0]  speed;
    logic [11:0] hor_pos;
    logic [10:0] ver_pos;
    logic        tick;
    logic [1:0]  hit;

    int n_total = 0;
    int n_bad   = 0;

    sprite_motion #(
        .HOR_FIELD(40),
        .VER_FIELD(30),
        .SIZE     (8),
        .HOR_W    (12),
        .VER_W    (11),
        .TICK_DIV (4),
        .RESET_HOR(0),
        .RESET_VER(0)
    ) u_dut (
        .clock  (clock),
        .reset  (reset),
        .control(control),
        .mode   (mode),
        .speed  (speed),
        .hor_pos(hor_pos),
        .ver_pos(ver_pos),
        .tick   (tick),
        .hit    (hit)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, act, exp);
        end
    endtask

    task automatic check_state(input string tag, input int h, input int v, input int hh);
        check_eq({tag, "_hor"}, 32'(hor_pos), 32'(h));
        check_eq({tag, "_ver"}, 32'(ver_pos), 32'(v));
        check_eq({tag, "_hit"}, 32'(hit), 32'(hh));
    endtask

    // Advance to a negedge inside a tick cycle, bounded.
    task automatic wait_tick();
        int k;
        k = 0;
        while (tick !== 1'b1 && k < 8) begin
            @(negedge clock);
            k++;
        end
        check_eq("tick_seen", 32'(tick), 32'd1);
    endtask

    // Wait for a tick and move to the cycle where its update is visible.
    task automatic tick_then();
        wait_tick();
        @(negedge clock);
    endtask

    initial begin
        reset   = 1'b1;
        mode    = 2'd0;
        control = 4'b0001;
        speed   = 4'd1;
        repeat (3) @(negedge clock);
        check_state("reset", 0, 0, 0);
        check_eq("reset_tick", 32'(tick), 32'd0);

        // Basic tick: cycle c is sampled at the c-th negedge after release.
        reset = 1'b0;
        for (int c = 1; c <= 13; c++) begin
            @(negedge clock);
            check_eq("basic_tick", 32'(tick), (c % 4 == 0) ? 32'd1 : 32'd0);
            check_state("basic", (c - 1) / 4, 0, 0);
        end

        // Clamp up to the right edge, then sit there.
        mode  = 2'd1;
        speed = 4'd15;
        tick_then();
        check_state("clamp_a", 18, 0, 0);
        tick_then();
        check_state("clamp_b", 32, 0, 2);
        @(negedge clock);
        check_eq("clamp_pulse", 32'(hit), 32'd0);
        tick_then();
        check_state("clamp_edge", 32, 0, 2);

        // Wrap in both directions on both axes.
        mode  = 2'd0;
        speed = 4'd3;
        tick_then();
        check_state("wrap_right", 2, 0, 0);
        control = 4'b0010;
        speed   = 4'd1;
        tick_then();
        check_state("wrap_left1", 1, 0, 0);
        speed = 4'd3;
        tick_then();
        check_state("wrap_left", 31, 0, 0);
        control = 4'b1000;
        speed   = 4'd2;
        tick_then();
        check_state("wrap_up", 31, 21, 0);

        // Clamp corner cases: opposing pair, bottom edge, zero speed.
        mode    = 2'd1;
        control = 4'b1100;
        speed   = 4'd5;
        tick_then();
        check_state("clamp_oppose", 31, 21, 0);
        control = 4'b0100;
        tick_then();
        check_state("clamp_down", 31, 22, 1);
        control = 4'b0110;
        speed   = 4'd0;
        tick_then();
        check_state("clamp_zero", 31, 22, 0);

        // Reset during a tick cycle discards the update.
        wait_tick();
        reset   = 1'b1;
        mode    = 2'd2;
        control = 4'b1111;
        speed   = 4'd5;
        @(negedge clock);
        check_state("rst_tick", 0, 0, 0);
        check_eq("rst_tick_tick", 32'(tick), 32'd0);
        reset = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clock);
            check_eq("rst_restart", 32'(tick), (c == 4) ? 32'd1 : 32'd0);
        end
        @(negedge clock);
        check_state("bounce_1", 5, 5, 0);

        // Bounce.
        tick_then();
        check_state("bounce_2", 10, 10, 0);
        tick_then();
        check_state("bounce_3", 15, 15, 0);
        tick_then();
        check_state("bounce_4", 20, 20, 0);
        tick_then();
        check_state("bounce_vref", 25, 19, 1);
        tick_then();
        check_state("bounce_6", 30, 14, 0);
        tick_then();
        check_state("bounce_href", 29, 9, 2);

        // Hold freezes position while the tick keeps running.
        mode = 2'd3;
        for (int i = 0; i < 3; i++) begin
            tick_then();
            check_state("hold", 29, 9, 0);
        end
        mode = 2'd2;
        tick_then();
        check_state("resume", 24, 4, 0);
        tick_then();
        check_state("resume_top", 19, 1, 1);

        // Corner: clamp both axes, then reflect both in one tick.
        reset = 1'b1;
        @(negedge clock);
        reset   = 1'b0;
        mode    = 2'd1;
        control = 4'b0101;
        speed   = 4'd15;
        tick_then();
        check_state("corner_a", 15, 15, 0);
        tick_then();
        check_state("corner_b", 30, 22, 1);
        tick_then();
        check_state("corner_c", 32, 22, 3);
        mode  = 2'd2;
        speed = 4'd1;
        tick_then();
        check_state("both_ref", 31, 21, 3);
        tick_then();
        check_state("both_after", 30, 20, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
